// File: rtl/es9821q_pkg.sv
// -----------------------------------------------------------------------------
// es9821q_pkg
// Shared types and constants for the ES9821Q I2S slave receiver.
//   state_e      : receiver state (IDLE, ALIGN, LEFT, RIGHT)
//   DATA_W_MIN   : narrowest supported captured sample width
//   DATA_W_MAX   : widest supported captured sample width
//   SYNC_STAGES  : flops in each pin synchroniser chain
// -----------------------------------------------------------------------------
package es9821q_pkg;

  localparam int DATA_W_MIN  = 16;
  localparam int DATA_W_MAX  = 32;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } state_e;

endpackage

// File: rtl/i2s_pin_sync.sv
// -----------------------------------------------------------------------------
// i2s_pin_sync
// Brings the three asynchronous I2S pins into the clk domain and flags BCLK
// rising edges.
//   clk, reset  : system clock, synchronous active-high reset
//   bclk, lrck, sdata : raw pins from the ADC (asynchronous)
//   bclk_rise   : one-cycle pulse, a BCLK rising edge was seen
//   lrck_s      : synchronised word select, aligned with bclk_rise
//   sdata_s     : synchronised serial data, aligned with bclk_rise
// All three outputs are registered so the edge pulse and the data it samples
// always leave this block on the same cycle.
// -----------------------------------------------------------------------------
module i2s_pin_sync
  import es9821q_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bclk,
  input  logic lrck,
  input  logic sdata,
  output logic bclk_rise,
  output logic lrck_s,
  output logic sdata_s
);

  // Bit order inside each stage: [2]=sdata, [1]=lrck, [0]=bclk.
  logic [2:0] sync_q [SYNC_STAGES];
  logic       bclk_last_q;
  logic       bclk_rise_q;
  logic       lrck_s_q;
  logic       sdata_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      bclk_last_q <= 1'b0;
      bclk_rise_q <= 1'b0;
      lrck_s_q    <= 1'b0;
      sdata_s_q   <= 1'b0;
    end else begin
      sync_q[0] <= {sdata, lrck, bclk};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      bclk_last_q <= sync_q[SYNC_STAGES-1][0];
      bclk_rise_q <= sync_q[SYNC_STAGES-1][0] & ~bclk_last_q;
      lrck_s_q    <= sync_q[SYNC_STAGES-1][1];
      sdata_s_q   <= sync_q[SYNC_STAGES-1][2];
    end
  end

  assign bclk_rise = bclk_rise_q;
  assign lrck_s    = lrck_s_q;
  assign sdata_s   = sdata_s_q;

endmodule

// File: rtl/es9821q_i2s_rx.sv
// -----------------------------------------------------------------------------
// es9821q_i2s_rx
// I2S slave receiver for the ES9821Q serial audio output. The ADC drives
// BCLK/LRCK/SDATA; this block oversamples them, deserialises MSB-first,
// left-aligned slots and hands each stereo pair downstream.
//
// Parameters
//   DATA_W : captured sample width (16..32)
//   CNT_W  : slot bit-counter width, counter saturates at 2^CNT_W-1
// Ports
//   clk, reset           : system clock (>= 4x BCLK), sync active-high reset
//   enable               : capture enable (config done)
//   bclk, lrck, sdata    : asynchronous I2S pins, lrck 0 = left, 1 = right
//   out_left, out_right  : held stereo pair, two's complement
//   out_valid, out_ready : pair handshake
//   overrun              : sticky, a completed pair was dropped
//   short_frame          : sticky, a slot closed with fewer than DATA_W bits
//   clr_status           : pulse, clears both sticky flags
//   dbg_state            : current receiver state
//
// Handshake: a transfer happens on every cycle where out_valid and out_ready
// are both 1. While out_valid=1 and out_ready=0 the pair and out_valid are
// held. out_ready may stay high permanently.
// -----------------------------------------------------------------------------
module es9821q_i2s_rx
  import es9821q_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              bclk,
  input  logic              lrck,
  input  logic              sdata,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              short_frame,
  input  logic              clr_status,
  output state_e            dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DW_CNT  = CNT_W'(DATA_W);

  // ---------------------------------------------------------------------------
  // Pin conditioning
  // ---------------------------------------------------------------------------
  logic bclk_rise;
  logic lrck_s;
  logic sdata_s;

  i2s_pin_sync u_pin_sync (
    .clk       (clk),
    .reset     (reset),
    .bclk      (bclk),
    .lrck      (lrck),
    .sdata     (sdata),
    .bclk_rise (bclk_rise),
    .lrck_s    (lrck_s),
    .sdata_s   (sdata_s)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic              lrck_prev_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;
  logic [DATA_W-1:0] left_hold_q;
  logic [DATA_W-1:0] out_left_q;
  logic [DATA_W-1:0] out_right_q;
  logic              out_valid_q;
  logic              overrun_q;
  logic              short_q;

  logic boundary;
  logic left_close;
  logic pair_done;
  logic short_set;
  logic xfer;
  logic load_pair;
  logic overrun_set;

  // ---------------------------------------------------------------------------
  // Slot datapath
  // The sample register is written by position rather than shifted: bit
  // number count goes to sr[DATA_W-1-count]. A slot that ends early is then
  // already left-justified with zero LSBs, and bits past DATA_W match no
  // position and fall away.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
    sr_d    = sr_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (count_q == CNT_W'(DATA_W - 1 - i)) begin
        sr_d[i] = sdata_s;
      end
    end
  end

  // The bit sampled on a boundary edge is still the last bit of the closing
  // slot (one-BCLK I2S delay), so closes use sr_d/count_d.
  assign boundary    = bclk_rise && (lrck_s != lrck_prev_q);
  assign left_close  = enable && (state_q == LEFT)  && boundary;
  assign pair_done   = enable && (state_q == RIGHT) && boundary;
  assign short_set   = (left_close || pair_done) && (count_d < DW_CNT);
  assign xfer        = out_valid_q && out_ready;
  assign load_pair   = pair_done && (!out_valid_q || out_ready);
  assign overrun_set = pair_done && !load_pair;

  // ---------------------------------------------------------------------------
  // Receiver FSM, output register and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lrck_prev_q <= 1'b0;
      count_q     <= '0;
      sr_q        <= '0;
      left_hold_q <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      // Set beats clear when both happen in one cycle.
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (clr_status) begin
        overrun_q <= 1'b0;
      end
      if (short_set) begin
        short_q <= 1'b1;
      end else if (clr_status) begin
        short_q <= 1'b0;
      end

      // A completing pair may replace one that is leaving this same cycle.
      if (load_pair) begin
        out_left_q  <= left_hold_q;
        out_right_q <= sr_d;
        out_valid_q <= 1'b1;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end

      if (!enable) begin
        state_q     <= IDLE;
        count_q     <= '0;
        sr_q        <= '0;
        lrck_prev_q <= lrck_s;
      end else begin
        case (state_q)
          IDLE: begin
            state_q     <= ALIGN;
            count_q     <= '0;
            sr_q        <= '0;
            lrck_prev_q <= lrck_s;
          end
          // Wait for a right->left change so the first pair is complete.
          ALIGN: begin
            if (bclk_rise) begin
              lrck_prev_q <= lrck_s;
              count_q     <= '0;
              sr_q        <= '0;
              if (boundary && !lrck_s) begin
                state_q <= LEFT;
              end
            end
          end
          LEFT: begin
            if (bclk_rise) begin
              lrck_prev_q <= lrck_s;
              if (boundary) begin
                left_hold_q <= sr_d;
                count_q     <= '0;
                sr_q        <= '0;
                state_q     <= RIGHT;
              end else begin
                count_q <= count_d;
                sr_q    <= sr_d;
              end
            end
          end
          RIGHT: begin
            if (bclk_rise) begin
              lrck_prev_q <= lrck_s;
              if (boundary) begin
                count_q <= '0;
                sr_q    <= '0;
                state_q <= LEFT;
              end else begin
                count_q <= count_d;
                sr_q    <= sr_d;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign out_left    = out_left_q;
  assign out_right   = out_right_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;
  assign short_frame = short_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_es9821q_i2s_rx.sv
// -----------------------------------------------------------------------------
// tb_es9821q_i2s_rx
// Plays the ADC as I2S master (BCLK = clk/8) and checks captured pairs,
// handshake behaviour and the sticky flags against a slot-level model.
// -----------------------------------------------------------------------------
module tb_es9821q_i2s_rx;
  import es9821q_pkg::*;

  localparam int DW = 24;
  localparam int CW = 6;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          bclk;
  logic          lrck;
  logic          sdata;
  logic [DW-1:0] out_left;
  logic [DW-1:0] out_right;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic          short_frame;
  logic          clr_status;
  state_e        dbg_state;

  always #5 clk = ~clk;

  es9821q_i2s_rx #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bclk        (bclk),
    .lrck        (lrck),
    .sdata       (sdata),
    .out_left    (out_left),
    .out_right   (out_right),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .short_frame (short_frame),
    .clr_status  (clr_status),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];   // expected left, right pushed in that order
  logic          pend;       // last bit of the previous right slot

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample a slot of n bits, MSB first, left aligned in a DW-bit word.
  function automatic logic [DW-1:0] model_word(input logic [127:0] slot, input int n);
    if (n >= DW) return DW'(slot >> (n - DW));
    else         return DW'(slot << (DW - n));
  endfunction

  function automatic logic [127:0] rand_slot(input int n);
    logic [127:0] v;
    logic [127:0] m;
    v = {$urandom, $urandom, $urandom, $urandom};
    m = (128'(1) << n) - 128'(1);
    return v & m;
  endfunction

  task automatic push_exp(input logic [127:0] l, input logic [127:0] r, input int n);
    exp_q.push_back(model_word(l, n));
    exp_q.push_back(model_word(r, n));
  endtask

  task automatic check_pair(input string tag);
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (exp_q.size() < 2) begin
      chk({tag, "_queue"}, 64'(exp_q.size()), 64'd2);
    end else begin
      el = exp_q.pop_front();
      er = exp_q.pop_front();
      chk({tag, "_left"},  64'(out_left),  64'(el));
      chk({tag, "_right"}, 64'(out_right), 64'(er));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end on a clk negedge)
  // ---------------------------------------------------------------------------
  task automatic send_bit(input logic lr, input logic d);
    bclk = 1'b0; lrck = lr; sdata = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_mid();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_left",  64'(out_left),  64'd0);
    chk("rst_right", 64'(out_right), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Everything of a frame except the closing edge, which is the first bit
  // time of the next left slot.
  task automatic send_body(input logic [127:0] l, input logic [127:0] r, input int n,
                           input int en_at, input int rst_at);
    for (int i = 0; i < n - 1; i++) begin
      if (i == en_at) enable = 1'b1;
      send_bit(1'b0, l[n-1-i]);
    end
    send_bit(1'b1, l[0]);
    for (int i = 0; i < n - 1; i++) begin
      if (i == rst_at) reset_mid();
      send_bit(1'b1, r[n-1-i]);
    end
    pend = r[0];
  endtask

  task automatic close_rise();
    bclk = 1'b0; lrck = 1'b0; sdata = pend;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
  endtask

  task automatic close_wait();
    close_rise();
    repeat (6) @(negedge clk);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_drop"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [127:0] l;
    logic [127:0] r;
    int           widths[8];

    reset = 1'b1; enable = 1'b0; bclk = 1'b0; lrck = 1'b1; sdata = 1'b0;
    out_ready = 1'b0; clr_status = 1'b0; pend = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_left",  64'(out_left),    64'd0);
    chk("reset_right", 64'(out_right),   64'd0);
    chk("reset_valid", 64'(out_valid),   64'd0);
    chk("reset_ovr",   64'(overrun),     64'd0);
    chk("reset_short", 64'(short_frame), 64'd0);
    chk("reset_state", 64'(dbg_state),   64'(IDLE));

    reset = 1'b0; enable = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("align_state", 64'(dbg_state), 64'(LEFT));

    // Nominal 32-bit slots with random padding bits, latency check.
    l = (128'(24'hA5A5A5) << 8) | 128'($urandom_range(0, 255));
    r = (128'(24'h5A5A5A) << 8) | 128'($urandom_range(0, 255));
    push_exp(l, r, 32);
    send_body(l, r, 32, -1, -1);
    close_rise();
    repeat (3) @(posedge clk); #1;
    chk("lat3_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat4_valid", 64'(out_valid), 64'd1);
    repeat (4) @(negedge clk);
    check_pair("nominal");
    chk("nominal_ovr",   64'(overrun),     64'd0);
    chk("nominal_short", 64'(short_frame), 64'd0);
    accept("nominal");

    // Short 16-bit slots.
    l = 128'(16'h1234);
    r = 128'(16'h8001);
    push_exp(l, r, 16);
    send_body(l, r, 16, -1, -1);
    close_wait();
    check_pair("short");
    chk("short_flag", 64'(short_frame), 64'd1);
    chk("short_ovr",  64'(overrun),     64'd0);
    accept("short");
    pulse_clr();
    chk("short_clr", 64'(short_frame), 64'd0);

    // Backpressure across three frames, then the fourth frame.
    l = rand_slot(32); r = rand_slot(32);
    push_exp(l, r, 32);
    send_body(l, r, 32, -1, -1);
    close_wait();
    for (int f = 0; f < 2; f++) begin
      send_body(rand_slot(32), rand_slot(32), 32, -1, -1);
      close_wait();
    end
    check_pair("bp_held");
    chk("bp_ovr", 64'(overrun), 64'd1);
    accept("bp");
    l = rand_slot(32); r = rand_slot(32);
    push_exp(l, r, 32);
    send_body(l, r, 32, -1, -1);
    close_wait();
    check_pair("bp_next");
    pulse_clr();
    chk("bp_ovr_clr", 64'(overrun), 64'd0);

    // Ready pulsed in the very cycle the next pair completes.
    l = rand_slot(32); r = rand_slot(32);
    push_exp(l, r, 32);
    send_body(l, r, 32, -1, -1);
    close_rise();
    repeat (3) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_pair("simul");
    chk("simul_ovr", 64'(overrun), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    accept("simul");

    // Enable rising in the middle of a left slot.
    enable = 1'b0;
    send_body(rand_slot(32), rand_slot(32), 32, 8, -1);
    close_wait();
    chk("en_discard", 64'(out_valid), 64'd0);
    l = rand_slot(32) | (128'(1) << 31); r = rand_slot(32) | (128'(1) << 31);
    push_exp(l, r, 32);
    send_body(l, r, 32, -1, -1);
    close_wait();
    check_pair("en_next");

    // Reset in the middle of a right slot while a pair is held.
    send_body(rand_slot(32), rand_slot(32), 32, -1, 10);
    close_wait();
    chk("rst_nopair", 64'(out_valid), 64'd0);
    l = rand_slot(32); r = rand_slot(32);
    push_exp(l, r, 32);
    send_body(l, r, 32, -1, -1);
    close_wait();
    check_pair("rst_next");
    accept("rst");

    // Slot widths around DATA_W, at the counter limit and beyond it.
    widths = '{23, 24, 25, 63, 70, 16, 16, 16};
    for (int k = 5; k < 8; k++) widths[k] = $urandom_range(16, 40);
    for (int k = 0; k < 8; k++) begin
      pulse_clr();
      l = rand_slot(widths[k]); r = rand_slot(widths[k]);
      push_exp(l, r, widths[k]);
      send_body(l, r, widths[k], -1, -1);
      close_wait();
      check_pair($sformatf("w%0d", widths[k]));
      chk($sformatf("w%0d_short", widths[k]), 64'(short_frame), 64'(widths[k] < DW));
      chk($sformatf("w%0d_ovr", widths[k]), 64'(overrun), 64'd0);
      accept($sformatf("w%0d", widths[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
